// File: rtl/object_counter.sv
// Object passage counter: qualifies a level detect flag with confirm/release persistence
// timers and counts each passage once. Define OBJ_COUNTER_WRAP_EN to wrap instead of saturate.
module object_counter #(
  parameter int CONFIRM_CYCLES = 5_000_000,
  parameter int RELEASE_CYCLES = 5_000_000,
  parameter int COUNT_W        = 16,
  parameter int MAX_COUNT      = 9999
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               object_detected_i,
  input  logic               enable_i,
  input  logic               clear_i,
  output logic [COUNT_W-1:0] count_o,
  output logic               count_pulse_o,
  output logic               object_present_o,
  output logic               full_o,
  output logic               overflow_o
);

  localparam int TMAX = (CONFIRM_CYCLES > RELEASE_CYCLES) ? CONFIRM_CYCLES : RELEASE_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0]      CONF_LAST = TW'(CONFIRM_CYCLES - 1);
  localparam logic [TW-1:0]      REL_LAST  = TW'(RELEASE_CYCLES - 1);
  localparam logic [COUNT_W-1:0] MAX_C     = COUNT_W'(MAX_COUNT);

  typedef enum logic [1:0] {IDLE, CONFIRM, PRESENT, RELEASE} state_t;

  state_t              state_q, state_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [COUNT_W-1:0]  count_q, count_d;
  logic                pulse_q, pulse_d;
  logic                present_q, present_d;
  logic                full_q, full_d;
  logic                ovf_q, ovf_d;
  logic                accept;

  // Count value after an accepted object; at the top either holds or wraps.
  function automatic logic [COUNT_W-1:0] bump(input logic [COUNT_W-1:0] c);
    if (c < MAX_C) return c + COUNT_W'(1);
`ifdef OBJ_COUNTER_WRAP_EN
    return '0;
`else
    return c;
`endif
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      count_q   <= '0;
      pulse_q   <= 1'b0;
      present_q <= 1'b0;
      full_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      count_q   <= count_d;
      pulse_q   <= pulse_d;
      present_q <= present_d;
      full_q    <= full_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    accept  = 1'b0;
    if (!enable_i) begin
      state_d = IDLE;
      timer_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (object_detected_i) begin
            if (CONFIRM_CYCLES == 1) begin
              state_d = PRESENT;
              timer_d = '0;
              accept  = 1'b1;
            end else begin
              state_d = CONFIRM;
              timer_d = TW'(1);
            end
          end
        end
        CONFIRM: begin
          if (!object_detected_i) begin
            state_d = IDLE;
            timer_d = '0;
          end else if (timer_q == CONF_LAST) begin
            state_d = PRESENT;
            timer_d = '0;
            accept  = 1'b1;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        PRESENT: begin
          if (!object_detected_i) begin
            if (RELEASE_CYCLES == 1) begin
              state_d = IDLE;
              timer_d = '0;
            end else begin
              state_d = RELEASE;
              timer_d = TW'(1);
            end
          end
        end
        RELEASE: begin
          // A short dropout returns to PRESENT without producing a second count.
          if (object_detected_i) begin
            state_d = PRESENT;
            timer_d = '0;
          end else if (timer_q == REL_LAST) begin
            state_d = IDLE;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (accept) begin
      count_d = bump(count_q);
      if (count_q >= MAX_C) ovf_d = 1'b1;
    end
    // Clear takes priority over a coincident accept; the strobe still fires.
    if (clear_i) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end
    full_d    = (count_d == MAX_C);
    pulse_d   = accept;
    present_d = (state_d == PRESENT) || (state_d == RELEASE);
  end

  assign count_o          = count_q;
  assign count_pulse_o    = pulse_q;
  assign object_present_o = present_q;
  assign full_o           = full_q;
  assign overflow_o       = ovf_q;

endmodule

// File: tb/tb_object_counter.sv
// Directed bench for object_counter with CONFIRM=4, RELEASE=3, COUNT_W=4, MAX_COUNT=5.
module tb_object_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       det = 1'b0;
  logic       en  = 1'b1;
  logic       clr = 1'b0;
  logic [3:0] count_o;
  logic       pulse_o, present_o, full_o, ovf_o;

  int n_cmp = 0;
  int n_err = 0;

`ifdef OBJ_COUNTER_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  object_counter #(
    .CONFIRM_CYCLES(4), .RELEASE_CYCLES(3), .COUNT_W(4), .MAX_COUNT(5)
  ) dut (
    .clk(clk), .rst(rst), .object_detected_i(det), .enable_i(en), .clear_i(clr),
    .count_o(count_o), .count_pulse_o(pulse_o), .object_present_o(present_o),
    .full_o(full_o), .overflow_o(ovf_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic det;
    logic clr;
    int   cnt;
    int   pulse;
    int   pres;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic d, input logic c, input int cnt, input int p, input int pr);
    vec_t v;
    v.det = d; v.clr = c; v.cnt = cnt; v.pulse = p; v.pres = pr;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Four high samples then three low; the accept lands on the fourth high edge.
  task automatic passage(input logic clr_acc, input int ecnt, input int eovf, input int efull);
    for (int i = 0; i < 4; i++) begin
      det = 1'b1; en = 1'b1; clr = (i == 3) ? clr_acc : 1'b0;
      tick();
      chk("pass_pulse", int'(pulse_o), (i == 3) ? 1 : 0);
      if (i == 3) begin
        chk("pass_cnt", int'(count_o), ecnt);
        chk("pass_ovf", int'(ovf_o), eovf);
        chk("pass_full", int'(full_o), efull);
        chk("pass_present", int'(present_o), 1);
      end
    end
    clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      det = 1'b0;
      tick();
    end
    chk("pass_idle_present", int'(present_o), 0);
  endtask

  initial begin
    // Scenario 1: long presence, single count, release after three lows.
    for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0);
    add(1, 0, 1, 1, 1);
    for (int i = 0; i < 6; i++) add(1, 0, 1, 0, 1);
    add(0, 0, 1, 0, 1); add(0, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) add(0, 0, 1, 0, 0);
    add(0, 1, 0, 0, 0);
    // Scenario 2: interrupted confirm windows never count.
    for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0);
    // Scenario 3: dropout shorter than release window is absorbed.
    for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0);
    add(1, 0, 1, 1, 1);
    add(0, 0, 1, 0, 1); add(0, 0, 1, 0, 1);
    add(1, 0, 1, 0, 1);
    add(0, 0, 1, 0, 1); add(0, 0, 1, 0, 1);
    add(0, 0, 1, 0, 0);

    #2;
    chk("rst_cnt", int'(count_o), 0);
    chk("rst_pulse", int'(pulse_o), 0);
    chk("rst_present", int'(present_o), 0);
    chk("rst_full", int'(full_o), 0);
    chk("rst_ovf", int'(ovf_o), 0);
    tick();
    rst = 1'b0;
    tick();

    foreach (vecs[i]) begin
      det = vecs[i].det; clr = vecs[i].clr; en = 1'b1;
      tick();
      chk($sformatf("vec%0d_cnt", i), int'(count_o), vecs[i].cnt);
      chk($sformatf("vec%0d_pulse", i), int'(pulse_o), vecs[i].pulse);
      chk($sformatf("vec%0d_present", i), int'(present_o), vecs[i].pres);
      chk($sformatf("vec%0d_full", i), int'(full_o), 0);
      chk($sformatf("vec%0d_ovf", i), int'(ovf_o), 0);
    end
    clr = 1'b0;

    // Scenario 4: fill to MAX_COUNT then one more passage.
    clr = 1'b1; det = 1'b0; tick(); clr = 1'b0;
    chk("s4_clear_cnt", int'(count_o), 0);
    for (int i = 1; i <= 5; i++) passage(1'b0, i, 0, (i == 5) ? 1 : 0);
    passage(1'b0, WRAP ? 0 : 5, 1, WRAP ? 0 : 1);
    chk("s4_ovf_sticky", int'(ovf_o), 1);

    // Scenario 5: clear coinciding with accept, first with overflow set, then at count 3.
    passage(1'b1, 0, 0, 0);
    for (int i = 1; i <= 3; i++) passage(1'b0, i, 0, 0);
    passage(1'b1, 0, 0, 0);

    // Scenario 6: asynchronous reset mid-confirm with count 2.
    passage(1'b0, 1, 0, 0);
    passage(1'b0, 2, 0, 0);
    det = 1'b1; tick(); tick();
    chk("s6_pre_cnt", int'(count_o), 2);
    #2 rst = 1'b1;
    #1;
    chk("s6_async_cnt", int'(count_o), 0);
    chk("s6_async_pulse", int'(pulse_o), 0);
    chk("s6_async_present", int'(present_o), 0);
    tick();
    rst = 1'b0;
    passage(1'b0, 1, 0, 0);

    // Enable low with input high: no counting, state held in IDLE.
    det = 1'b1; en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("dis_pulse", int'(pulse_o), 0);
      chk("dis_present", int'(present_o), 0);
    end
    chk("dis_cnt", int'(count_o), 1);
    passage(1'b0, 2, 0, 0);

    // Disable while PRESENT, re-enable with input still high: fresh confirm window.
    det = 1'b1; en = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("pres_cnt", int'(count_o), 3);
    en = 1'b0; tick();
    chk("pres_dis_present", int'(present_o), 0);
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reen_pulse", int'(pulse_o), 0);
    end
    tick();
    chk("reen_accept_pulse", int'(pulse_o), 1);
    chk("reen_accept_cnt", int'(count_o), 4);
    det = 1'b0;
    for (int i = 0; i < 3; i++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
